// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul
// Iterative shift-add multiplier with a valid/ready handshake on both sides.
// Signed operands are converted to magnitudes on acceptance. The magnitudes are
// multiplied one multiplier bit per clock. The sign is applied once, on the last
// step. Latency is fixed at WIDTH cycles from the accepting edge to out_valid.
// There is no early exit for zero operands.

module seq_shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WIDTH-1:0]    r_mag_a;
    logic [WIDTH-1:0]    r_mag_b;
    logic                r_neg;
    logic [2*WIDTH-1:0]  r_acc;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_product;

    logic                w_accept;
    logic                w_last_step;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [2*WIDTH-1:0]  w_addend;
    logic [2*WIDTH-1:0]  w_acc_sum;
    logic [2*WIDTH-1:0]  w_result;

    // Magnitudes: -2^(WIDTH-1) negates to itself. Read as unsigned, it is the correct magnitude.
    assign w_mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    assign w_accept    = in_valid && in_ready;
    assign w_last_step = (r_state == S_BUSY) && (r_cnt == LAST_BIT);

    // Partial product for the current multiplier bit, zero-extended before the shift.
    assign w_addend  = r_mag_b[r_cnt] ? ({{WIDTH{1'b0}}, r_mag_a} << r_cnt) : '0;
    assign w_acc_sum = r_acc + w_addend;
    assign w_result  = r_neg ? -w_acc_sum : w_acc_sum;

    assign product   = r_product;

    // State register with synchronous reset.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (w_accept) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, retire one multiplier bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath is cleared too. A discarded op must not leave a stale product visible.
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + CW'(1);
            if (w_last_step) begin
                r_product <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul
// Scoreboard bench for seq_shift_add_mul with a WIDTH=4 and a WIDTH=8 instance.
// Expected products come from integer arithmetic on the operands.

module tb_seq_shift_add_mul;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  product;
    logic        busy;

    logic        in_valid_8;
    logic        in_ready_8;
    logic [7:0]  a_8;
    logic [7:0]  b_8;
    logic        is_signed_8;
    logic        out_valid_8;
    logic        out_ready_8;
    logic [15:0] product_8;
    logic        busy_8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp_q8[$];

    always #5 clk = ~clk;

    seq_shift_add_mul #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    seq_shift_add_mul #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_8),
        .in_ready  (in_ready_8),
        .a         (a_8),
        .b         (b_8),
        .is_signed (is_signed_8),
        .out_valid (out_valid_8),
        .out_ready (out_ready_8),
        .product   (product_8),
        .busy      (busy_8)
    );

    function automatic logic [7:0] golden4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int ix;
        int iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return 8'(ix * iy);
    endfunction

    function automatic logic [15:0] golden8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int ix;
        int iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return 16'(ix * iy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands after an idle gap, wait for acceptance, push the expected product.
    task automatic send_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                           input int gap, output bit ok);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        a = ta; b = tb_v; is_signed = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        ok = (in_ready === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid  = 1'b0;
            a         = 4'($urandom);
            b         = 4'($urandom);
            is_signed = 1'($urandom);
            exp_q.push_back(golden4(ta, tb_v, ts));
        end
    endtask

    task automatic wait_out(output logic [7:0] p, output int cycles, output bit ok);
        cycles = 0;
        while (!out_valid && cycles < 30) begin tick(); cycles++; end
        ok = (out_valid === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        p = product;
    endtask

    task automatic pop_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic send_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                            input int gap, output bit ok);
        int n;
        in_valid_8 = 1'b0;
        repeat (gap) tick();
        a_8 = ta; b_8 = tb_v; is_signed_8 = ts; in_valid_8 = 1'b1;
        n = 0;
        while (!in_ready_8 && n < 30) begin tick(); n++; end
        ok = (in_ready_8 === 1'b1);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL in_ready8_timeout: in_ready=%b required 1", in_ready_8);
            in_valid_8 = 1'b0;
        end else begin
            tick();
            in_valid_8  = 1'b0;
            a_8         = 8'($urandom);
            b_8         = 8'($urandom);
            exp_q8.push_back(golden8(ta, tb_v, ts));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; is_signed_8 = 1'b0; out_ready_8 = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (product !== 8'h00) begin errors++; $display("FAIL reset_product: got %h required 00", product); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_unsigned_max();
        bit ok;
        logic [7:0] exp;
        send_op(4'hF, 4'hF, 1'b0, 0, ok);
        if (ok) begin
            for (int k = 1; k <= 4; k++) begin
                tick();
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL umax_busy cycle %0d: got %b required 1", k, busy); end
                checks++;
                if (out_valid !== 1'(k == 4)) begin
                    errors++; $display("FAIL umax_latency cycle %0d: out_valid=%b required %b", k, out_valid, 1'(k == 4));
                end
            end
            exp = exp_q.pop_front();
            checks++; if (product !== exp) begin errors++; $display("FAIL umax_product: got %h required %h", product, exp); end
            pop_done();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL umax_drop_valid: got %b required 0", out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL umax_in_ready: got %b required 1", in_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL umax_busy_idle: got %b required 0", busy); end
        end
    endtask

    // Signed corner cases, the same operands unsigned, and zero operands at full latency.
    task automatic test_signed_and_zero();
        logic [3:0] ta [7] = '{4'h8, 4'h8, 4'h8, 4'h7, 4'hF, 4'h0, 4'h9};
        logic [3:0] tb_v [7] = '{4'h8, 4'h7, 4'h7, 4'h9, 4'h1, 4'hB, 4'h0};
        logic       ts [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bit ok;
        int cyc;
        logic [7:0] p;
        logic [7:0] exp;
        for (int i = 0; i < 7; i++) begin
            send_op(ta[i], tb_v[i], ts[i], 1, ok);
            if (ok) begin
                wait_out(p, cyc, ok);
                exp = exp_q.pop_front();
                if (ok) begin
                    checks++;
                    if (cyc != 4) begin errors++; $display("FAIL sgn_latency op %0d: got %0d cycles required 4", i, cyc); end
                    checks++;
                    if (p !== exp) begin errors++; $display("FAIL sgn_product op %0d: got %h required %h", i, p, exp); end
                    pop_done();
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        logic [7:0] p;
        logic [7:0] exp;
        send_op(4'hD, 4'h6, 1'b1, 0, ok);
        if (ok) begin
            wait_out(p, cyc, ok);
            exp = exp_q.pop_front();
            if (ok) begin
                for (int k = 0; k < 10; k++) begin
                    tick();
                    checks++;
                    if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cycle %0d: out_valid=%b product=%h in_ready=%b required 1 %h 0",
                                 k, out_valid, product, in_ready, exp);
                    end
                end
                pop_done();
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        int cyc;
        logic [7:0] p;
        logic [7:0] exp;
        send_op(4'hF, 4'hF, 1'b0, 0, ok);
        if (ok) begin
            tick();
            rst = 1'b1;
            tick();
            exp_q.delete();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
            checks++; if (product !== 8'h00) begin errors++; $display("FAIL rstmid_product: got %h required 00", product); end
            rst = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b required 1", in_ready); end
            send_op(4'h3, 4'h5, 1'b0, 0, ok);
            if (ok) begin
                wait_out(p, cyc, ok);
                exp = exp_q.pop_front();
                if (ok) begin
                    checks++; if (cyc != 4) begin errors++; $display("FAIL rstmid_latency: got %0d required 4", cyc); end
                    checks++; if (p !== exp) begin errors++; $display("FAIL rstmid_product_next: got %h required %h", p, exp); end
                    pop_done();
                end
            end
        end
    endtask

    // in_valid and out_ready held high: one result every WIDTH+2 cycles.
    task automatic test_back_to_back();
        int idx[$];
        logic [7:0] exp;
        int n;
        exp = golden4(4'h2, 4'h3, 1'b0);
        a = 4'h2; b = 4'h3; is_signed = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                idx.push_back(i);
                checks++;
                if (product !== exp) begin errors++; $display("FAIL b2b_product cycle %0d: got %h required %h", i, product, exp); end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (idx.size() < 3) begin
            errors++; $display("FAIL b2b_count: got %0d results required at least 3", idx.size());
        end else begin
            checks++;
            if (idx[1] - idx[0] != 6 || idx[2] - idx[1] != 6) begin
                errors++; $display("FAIL b2b_interval: got %0d,%0d required 6,6", idx[1] - idx[0], idx[2] - idx[1]);
            end
        end
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_exhaustive();
        bit ok;
        int cyc;
        logic [7:0] p;
        logic [7:0] exp;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    send_op(4'(x), 4'(y), 1'(s), $urandom_range(0, 2), ok);
                    if (ok) begin
                        wait_out(p, cyc, ok);
                        exp = exp_q.pop_front();
                        if (ok) begin
                            repeat ($urandom_range(0, 2)) tick();
                            checks++;
                            if (product !== exp || cyc != 4) begin
                                errors++;
                                $display("FAIL exh s=%0d a=%h b=%h: got %h after %0d cycles required %h after 4",
                                         s, x[3:0], y[3:0], product, cyc, exp);
                            end
                            pop_done();
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random_w8();
        bit ok;
        int cyc;
        logic [15:0] exp;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rs;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (i == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
            send_op8(ra, rb, rs, $urandom_range(0, 1), ok);
            if (ok) begin
                cyc = 0;
                while (!out_valid_8 && cyc < 40) begin tick(); cyc++; end
                exp = exp_q8.pop_front();
                checks++;
                if (out_valid_8 !== 1'b1 || cyc != 8 || product_8 !== exp) begin
                    errors++;
                    $display("FAIL w8 op %0d a=%h b=%h s=%b: valid=%b product=%h after %0d cycles required %h after 8",
                             i, ra, rb, rs, out_valid_8, product_8, cyc, exp);
                end
                repeat ($urandom_range(0, 1)) tick();
                out_ready_8 = 1'b1;
                tick();
                out_ready_8 = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_and_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_exhaustive();
        test_random_w8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
